// File: rtl/video_palette_expander_if.sv
// Pixel, sync and palette-write signals shared between the video source and the expander.
interface video_palette_expander_if;
  logic        ce_pix;
  logic [3:0]  pix_idx;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblank_in;
  logic        vblank_in;
  logic        pal_wr;
  logic [3:0]  pal_addr;
  logic [17:0] pal_data;
  logic        pal_err_clr;
  logic        pal_busy;
  logic        pal_err;
  logic [7:0]  R;
  logic [7:0]  G;
  logic [7:0]  B;
  logic        hsync_out;
  logic        vsync_out;
  logic        de_out;

  modport master (
    output ce_pix, pix_idx, hsync_in, vsync_in, hblank_in, vblank_in,
    output pal_wr, pal_addr, pal_data, pal_err_clr,
    input  pal_busy, pal_err, R, G, B, hsync_out, vsync_out, de_out
  );

  modport slave (
    input  ce_pix, pix_idx, hsync_in, vsync_in, hblank_in, vblank_in,
    input  pal_wr, pal_addr, pal_data, pal_err_clr,
    output pal_busy, pal_err, R, G, B, hsync_out, vsync_out, de_out
  );
endinterface

// File: rtl/video_palette_expander.sv
// IRGB index to 8-bit RGB expander with a 16-entry programmable palette.
// Palette writes are held in a pending register and committed during blanking.
module video_palette_expander #(
  parameter bit DEFER_TO_BLANK = 1'b1
) (
  input logic                     clk_vid,
  input logic                     reset,
  video_palette_expander_if.slave vid
);

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_PENDING = 1'b1;

  // CGA default for one entry; entry 6 gets the brown fix.
  function automatic logic [17:0] cga_default(input logic [3:0] idx);
    logic [5:0] lo;
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
    lo = idx[3] ? 6'h15 : 6'h00;
    r  = (idx[2] ? 6'h2A : 6'h00) | lo;
    g  = (idx[1] ? 6'h2A : 6'h00) | lo;
    b  = (idx[0] ? 6'h2A : 6'h00) | lo;
    if (idx == 4'd6) begin
      return {6'h2A, 6'h15, 6'h00};
    end
    return {r, g, b};
  endfunction

  function automatic logic [7:0] expand(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

  logic [17:0] r_pal [16];
  logic        r_state;
  logic        w_state_d;
  logic [3:0]  r_pend_addr;
  logic [17:0] r_pend_data;
  logic        r_err;

  logic [17:0] r_s1_data;
  logic        r_s1_hs;
  logic        r_s1_vs;
  logic        r_s1_blank;

  logic [7:0]  r_r;
  logic [7:0]  r_g;
  logic [7:0]  r_b;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;

  logic        w_blank;
  logic        w_busy;
  logic        w_accept;
  logic        w_drop;
  logic        w_commit;

  assign w_blank  = vid.hblank_in | vid.vblank_in;
  assign w_busy   = (r_state == ST_PENDING);
  assign w_accept = vid.pal_wr & ~w_busy;
  // Busy stays high on the commit edge, so a write there is dropped too.
  assign w_drop   = vid.pal_wr & w_busy;
  assign w_commit = w_busy & vid.ce_pix & (w_blank | ~DEFER_TO_BLANK);

  // Commit FSM next state.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_d = ST_PENDING;
      ST_PENDING: if (w_commit) w_state_d = ST_IDLE;
      default:    w_state_d = ST_IDLE;
    endcase
  end

  // FSM state, pending write capture and sticky error flag.
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pend_addr <= 4'd0;
      r_pend_data <= 18'd0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_pend_addr <= vid.pal_addr;
        r_pend_data <= vid.pal_data;
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop) begin
        r_err <= 1'b1;
      end else if (vid.pal_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  // Palette storage; reset restores the CGA defaults and discards any pending write.
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_pal[i] <= cga_default(4'(i));
      end
    end else if (w_commit) begin
      r_pal[r_pend_addr] <= r_pend_data;
    end
  end

  // Stage 1: palette lookup (old value on a commit edge) and sync/blank capture.
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      r_s1_data  <= 18'd0;
      r_s1_hs    <= 1'b0;
      r_s1_vs    <= 1'b0;
      r_s1_blank <= 1'b0;
    end else if (vid.ce_pix) begin
      r_s1_data  <= r_pal[vid.pix_idx];
      r_s1_hs    <= vid.hsync_in;
      r_s1_vs    <= vid.vsync_in;
      r_s1_blank <= w_blank;
    end
  end

  // Stage 2: channel expansion with blank forcing black; syncs pass ungated.
  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      r_r  <= 8'd0;
      r_g  <= 8'd0;
      r_b  <= 8'd0;
      r_hs <= 1'b0;
      r_vs <= 1'b0;
      r_de <= 1'b0;
    end else if (vid.ce_pix) begin
      r_r  <= r_s1_blank ? 8'd0 : expand(r_s1_data[17:12]);
      r_g  <= r_s1_blank ? 8'd0 : expand(r_s1_data[11:6]);
      r_b  <= r_s1_blank ? 8'd0 : expand(r_s1_data[5:0]);
      r_hs <= r_s1_hs;
      r_vs <= r_s1_vs;
      r_de <= ~r_s1_blank;
    end
  end

  assign vid.pal_busy  = w_busy;
  assign vid.pal_err   = r_err;
  assign vid.R         = r_r;
  assign vid.G         = r_g;
  assign vid.B         = r_b;
  assign vid.hsync_out = r_hs;
  assign vid.vsync_out = r_vs;
  assign vid.de_out    = r_de;

endmodule

// File: tb/tb_video_palette_expander.sv
// Directed bench for video_palette_expander: stimulus pushes expected pixels into a
// scoreboard queue, a monitor pops them as the pipeline presents each result.
module tb_video_palette_expander;

  logic clk_vid = 1'b0;
  logic reset;

  video_palette_expander_if vid ();

  video_palette_expander #(
    .DEFER_TO_BLANK(1'b1)
  ) dut (
    .clk_vid (clk_vid),
    .reset   (reset),
    .vid     (vid)
  );

  always #5 clk_vid = ~clk_vid;

  // {R, G, B, hsync, vsync, de}
  typedef logic [26:0] pix_t;

  pix_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Monitor: each enable presents the result of the previous enable's input.
  initial begin : monitor
    int   n;
    bit   have_last;
    pix_t last;
    pix_t got;
    n = 0;
    have_last = 1'b0;
    last = '0;
    forever begin
      @(posedge clk_vid);
      if (reset) begin
        n = 0;
        have_last = 1'b0;
        exp_q.delete();
      end else if (vid.ce_pix) begin
        n++;
        #1;
        if (n >= 2) begin
          got = {vid.R, vid.G, vid.B, vid.hsync_out, vid.vsync_out, vid.de_out};
          if (exp_q.size() == 0) begin
            chk("pix_queue_empty", 32'(exp_q.size()), 32'd1);
          end else begin
            last = exp_q.pop_front();
            have_last = 1'b1;
            chk("pix", 32'(got), 32'(last));
          end
        end
      end else begin
        #1;
        if (have_last) begin
          got = {vid.R, vid.G, vid.B, vid.hsync_out, vid.vsync_out, vid.de_out};
          chk("pix_hold", 32'(got), 32'(last));
        end
      end
    end
  end

  // One pixel enable; called and returns at a falling edge.
  task automatic enable(input logic [3:0] idx, input logic hs, input logic vs,
                        input logic hb, input logic vb,
                        input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    vid.pix_idx   = idx;
    vid.hsync_in  = hs;
    vid.vsync_in  = vs;
    vid.hblank_in = hb;
    vid.vblank_in = vb;
    vid.ce_pix    = 1'b1;
    @(posedge clk_vid);
    exp_q.push_back({er, eg, eb, hs, vs, ~(hb | vb)});
    @(negedge clk_vid);
    vid.ce_pix = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_vid);
  endtask

  task automatic pal_write(input logic [3:0] addr, input logic [17:0] data);
    vid.pal_wr   = 1'b1;
    vid.pal_addr = addr;
    vid.pal_data = data;
    @(negedge clk_vid);
    vid.pal_wr = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_R", 32'(vid.R), 32'h00);
    chk("rst_G", 32'(vid.G), 32'h00);
    chk("rst_B", 32'(vid.B), 32'h00);
    chk("rst_syncs_de", 32'({vid.hsync_out, vid.vsync_out, vid.de_out}), 32'd0);
    chk("rst_busy", 32'(vid.pal_busy), 32'd0);
    chk("rst_err", 32'(vid.pal_err), 32'd0);
  endtask

  initial begin : stim
    reset           = 1'b1;
    vid.ce_pix      = 1'b0;
    vid.pix_idx     = 4'd0;
    vid.hsync_in    = 1'b0;
    vid.vsync_in    = 1'b0;
    vid.hblank_in   = 1'b0;
    vid.vblank_in   = 1'b0;
    vid.pal_wr      = 1'b0;
    vid.pal_addr    = 4'd0;
    vid.pal_data    = 18'd0;
    vid.pal_err_clr = 1'b0;
    idle(2);
    check_reset_state();
    reset = 1'b0;
    idle(1);

    // Default colours: brown fix, white, black.
    enable(4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 8'h55, 8'h00);
    enable(4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    enable(4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

    // Latency with enable every second clock; hsync edge tracks colour change.
    enable(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hAA);
    idle(1);
    enable(4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 8'h55, 8'hFF);
    idle(1);
    enable(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 8'h55, 8'hFF);
    idle(1);

    // Deferred write: old colour until a blanking enable commits.
    pal_write(4'd1, {6'h3F, 6'h00, 6'h00});
    chk("busy_after_wr", 32'(vid.pal_busy), 32'd1);
    enable(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hAA);
    chk("busy_active", 32'(vid.pal_busy), 32'd1);
    enable(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("busy_after_commit", 32'(vid.pal_busy), 32'd0);
    enable(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00);

    // Collision while pending: only the first write commits.
    pal_write(4'd2, {6'h00, 6'h3F, 6'h00});
    chk("err_after_accept", 32'(vid.pal_err), 32'd0);
    pal_write(4'd3, {6'h3F, 6'h3F, 6'h3F});
    chk("err_collision", 32'(vid.pal_err), 32'd1);
    vid.pal_err_clr = 1'b1;
    idle(1);
    vid.pal_err_clr = 1'b0;
    chk("err_cleared", 32'(vid.pal_err), 32'd0);
    enable(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hAA, 8'h00);
    // Write presented on the commit edge is dropped.
    vid.pal_wr   = 1'b1;
    vid.pal_addr = 4'd4;
    vid.pal_data = {6'h3F, 6'h3F, 6'h3F};
    enable(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    vid.pal_wr = 1'b0;
    chk("err_commit_edge", 32'(vid.pal_err), 32'd1);
    chk("busy_commit_edge", 32'(vid.pal_busy), 32'd0);
    enable(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00);
    enable(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hAA, 8'hAA);
    enable(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 8'h00, 8'h00);
    vid.pal_err_clr = 1'b1;
    idle(1);
    vid.pal_err_clr = 1'b0;
    chk("err_clr2", 32'(vid.pal_err), 32'd0);

    // Set beats clear when both land together.
    pal_write(4'd5, {6'h15, 6'h15, 6'h15});
    vid.pal_err_clr = 1'b1;
    pal_write(4'd7, {6'h00, 6'h00, 6'h00});
    vid.pal_err_clr = 1'b0;
    chk("err_set_wins", 32'(vid.pal_err), 32'd1);
    vid.pal_err_clr = 1'b1;
    idle(1);
    vid.pal_err_clr = 1'b0;
    chk("err_clr3", 32'(vid.pal_err), 32'd0);
    enable(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    enable(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 8'h55, 8'h55);
    enable(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 8'hAA, 8'hAA);

    // Vertical blanking: black, de low, vsync passes.
    enable(4'd15, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    enable(4'd15, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    enable(4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    enable(4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

    // Reset with a write pending: discarded, palette back to defaults.
    pal_write(4'd1, {6'h00, 6'h00, 6'h3F});
    chk("busy_before_reset", 32'(vid.pal_busy), 32'd1);
    reset = 1'b1;
    idle(2);
    check_reset_state();
    reset = 1'b0;
    idle(1);
    chk("busy_after_reset", 32'(vid.pal_busy), 32'd0);
    enable(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hAA);
    enable(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    enable(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hAA);
    enable(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_palette_expander.md
Name: video_palette_expander

Overview:
- Converts a 4-bit IRGB pixel index stream into 8-bit R/G/B. This is the colour source that drives the monochrome converter stage downstream.
- Holds a 16-entry programmable palette of 6-bit-per-channel values. Reset loads the CGA defaults, including the brown fix.
- CPU-side palette writes are deferred and committed only during blanking, so no visible tearing occurs.
- A 2-stage pipeline, advanced by ce_pix, keeps syncs and display-enable aligned with the colour data.

Parameters:
- DEFER_TO_BLANK, 1, 1 = commit palette writes only when hblank_in or vblank_in is high; 0 = commit on the next ce_pix.

Ports:
- clk_vid  in  1  video clock
- reset  in  1  asynchronous, active-high reset
- ce_pix  in  1  pixel clock enable; the pipeline advances only when this is high
- pix_idx  in  4  pixel index, bits {I,R,G,B}
- hsync_in  in  1  horizontal sync, passed through
- vsync_in  in  1  vertical sync, passed through
- hblank_in  in  1  horizontal blanking
- vblank_in  in  1  vertical blanking
- pal_wr  in  1  single-cycle palette write request
- pal_addr  in  4  palette entry to write
- pal_data  in  18  {R6,G6,B6}
- pal_busy  out  1  a write is pending, not yet committed
- pal_err  out  1  sticky flag: pal_wr was dropped because pal_busy was high
- pal_err_clr  in  1  clears pal_err
- R  out  8  red output
- G  out  8  green output
- B  out  8  blue output
- hsync_out  out  1  hsync aligned to R/G/B
- vsync_out  out  1  vsync aligned to R/G/B
- de_out  out  1  display enable aligned to R/G/B

Behaviour:
- Reset (async, high):
  - R, G, B = 0; hsync_out, vsync_out, de_out = 0; pal_busy = 0; pal_err = 0; pending register cleared.
  - Palette loaded with CGA defaults. Entry i: c = 0x2A per set bit of R/G/B, plus 0x15 on every channel if I is set.
  - Entry 6 is forced to {0x2A,0x15,0x00} (brown). Entry 8 = {0x15,0x15,0x15}.
- Channel expansion, 6 to 8 bits: out = {v[5:0], v[5:4]}. So 0x00→0x00, 0x15→0x55, 0x2A→0xAA, 0x3F→0xFF.
- Pipeline (each stage updates only on a clk_vid edge with ce_pix = 1; all registers hold otherwise):
  - Stage 1 registers palette[pix_idx] (18 bits), hsync_in, vsync_in, and blank = hblank_in|vblank_in.
  - Stage 2 registers R/G/B = expand(stage1 data), or 0 if stage1 blank = 1. It also registers hsync_out, vsync_out, and de_out = ~stage1 blank.
  - Latency is exactly 2 ce_pix enables for colour, syncs and de alike.
- Write handshake:
  - pal_wr is accepted on any clk_vid edge where pal_busy = 0, independent of ce_pix. pal_addr and pal_data are captured into the pending register and pal_busy goes to 1 on the next cycle.
  - pal_wr with pal_busy = 1: request dropped, pal_err goes to 1.
  - pal_err_clr clears pal_err. If pal_err_clr and a dropped pal_wr occur in the same cycle, set wins.
- Commit state machine, states IDLE and PENDING:
  - IDLE → PENDING on an accepted pal_wr.
  - PENDING → IDLE on a ce_pix cycle where (hblank_in|vblank_in) = 1, or on any ce_pix cycle if DEFER_TO_BLANK = 0. The palette entry is written on that edge and pal_busy drops on the same edge.
  - Read-before-write: a stage-1 lookup on the commit edge returns the old entry value.
  - A pal_wr on the commit edge is dropped and sets pal_err, because pal_busy is still 1 in that cycle.
- Reset mid-operation: a pending write is discarded, not committed, and the palette reverts to defaults.
- pix_idx is always in range; the palette has no wrap case.
- Syncs are never gated by blank.

Test Plan:
1. Release reset; drive pix_idx = 6, blank = 0 for 2 ce_pix → R=0xAA, G=0x55, B=0x00, de_out = 1. With pix_idx = 15 → FF/FF/FF. With pix_idx = 0 → 00/00/00.
2. Latency: toggle hsync_in and step pix_idx 1→9 with ce_pix high every 2nd clk_vid → colour change (00/00/AA → 55/55/FF) and hsync_out edge appear together after exactly 2 enables. Outputs hold steady on ce_pix-low cycles.
3. Deferred write: during active video, pal_wr with addr 1, data {0x3F,0,0}:
   - pal_busy = 1 and pix_idx = 1 still yields 00/00/AA.
   - On the first ce_pix with hblank_in = 1, pal_busy drops.
   - Next active pix_idx = 1 → FF/00/00.
4. Collision: second pal_wr while pal_busy = 1 → pal_err = 1, and only the first write commits. Then pal_err_clr → pal_err = 0.
5. Blanking: vblank_in = 1 with pix_idx = 15 → R/G/B = 0 and de_out = 0 after 2 enables, while vsync passes through unchanged.
6. Reset mid-pending: after pal_wr to entry 1, assert reset before any blank → pal_busy = 0, and entry 1 reads back as default 00/00/AA after release.
